// File: rtl/b2a_pkg.sv
// Shared constants and read-FSM encoding for the beta-to-alpha normalize/replay block.
package b2a_pkg;

  localparam int DW      = 8;
  localparam int SAT_MIN = -128;
  localparam int SAT_MAX = 127;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_e;

endpackage

// File: rtl/beta2alpha_fix_if.sv
// Beta input stream and alpha column output stream of beta2alpha_fix.
interface beta2alpha_fix_if #(
  parameter int J  = 4,
  parameter int A  = 4,
  parameter int DW = b2a_pkg::DW
);

  logic [A*DW-1:0] beta;
  logic            beta_tvalid;
  logic [J*DW-1:0] alpha_u_col;
  logic            alpha_u_col_tvalid;
  logic            alpha_u_col_tlast;
  logic            alpha_u_col_tready;

  modport master (
    output beta, beta_tvalid, alpha_u_col_tready,
    input  alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast
  );

  modport slave (
    input  beta, beta_tvalid, alpha_u_col_tready,
    output alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast
  );

endinterface

// File: rtl/beta_norm_fix.sv
// Combinational max-subtract normalization of one beta vector, saturated to DW-bit signed.
module beta_norm_fix
  import b2a_pkg::*;
#(
  parameter int A  = 4,
  parameter int DW = b2a_pkg::DW
) (
  input  logic [A*DW-1:0] beta,
  output logic [A*DW-1:0] n
);

  localparam logic signed [DW:0] SatMinW = (DW+1)'(SAT_MIN);
  localparam logic signed [DW:0] SatMaxW = (DW+1)'(SAT_MAX);

  logic signed [DW-1:0] max_v;
  logic signed [DW:0]   diff;

  // NOTE: every variable gets a value on every path before use, so no latch is inferred.
  always_comb begin
    max_v = beta[DW-1:0];
    for (int a = 1; a < A; a++) begin
      if ($signed(beta[a*DW +: DW]) > max_v) max_v = beta[a*DW +: DW];
    end
    n    = '0;
    diff = '0;
    for (int a = 0; a < A; a++) begin
      // One extra bit holds the full [-2^DW+1, 0] difference before clamping.
      diff = $signed({beta[a*DW+DW-1], beta[a*DW +: DW]}) - $signed({max_v[DW-1], max_v});
      if (diff < SatMinW)      n[a*DW +: DW] = SatMinW[DW-1:0];
      else if (diff > SatMaxW) n[a*DW +: DW] = SatMaxW[DW-1:0];
      else                     n[a*DW +: DW] = diff[DW-1:0];
    end
  end

endmodule

// File: rtl/beta2alpha_fix.sv
// Normalizes beta vectors into a two-bank ping-pong frame store and replays each
// frame column-wise as alpha_u_col beats for the next core iteration.
module beta2alpha_fix
  import b2a_pkg::*;
#(
  parameter int J  = 4,
  parameter int A  = 4,
  parameter int DW = b2a_pkg::DW
) (
  input  logic              clk,
  input  logic              rst_n,
  beta2alpha_fix_if.slave   bus,
  output logic              overflow,
  output logic [15:0]       frame_cnt
);

  localparam int JW = $clog2(J);
  localparam int AW = $clog2(A);
  localparam logic [JW-1:0] JLast = JW'(J-1);
  localparam logic [AW-1:0] ALast = AW'(A-1);

  logic [A*DW-1:0] norm;

  beta_norm_fix #(.A(A), .DW(DW)) u_norm (
    .beta (bus.beta),
    .n    (norm)
  );

  logic [DW-1:0]   bank_q [2][J][A];
  logic [1:0]      full_q, full_d;
  logic            wb_q, wb_d, rb_q, rb_d;
  logic [JW-1:0]   wj_q, wj_d;
  logic [AW-1:0]   ra_q, ra_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  rd_state_e       state_q, state_d;
  logic [J*DW-1:0] col_q, col_d;
  logic            valid_q, valid_d, last_q, last_d;
  logic            wr_en, wr_last, rd_free, load, ld_bank;
  logic [AW-1:0]   ld_col;

  always_comb begin
    wr_en      = bus.beta_tvalid && !full_q[wb_q];
    wr_last    = wr_en && (wj_q == JLast);
    wj_d       = wj_q;
    wb_d       = wb_q;
    overflow_d = overflow_q | (bus.beta_tvalid && full_q[wb_q]);
    if (wr_en)   wj_d = wr_last ? '0 : wj_q + JW'(1);
    if (wr_last) wb_d = ~wb_q;
  end

  always_comb begin
    state_d     = state_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    frame_cnt_d = frame_cnt_q;
    valid_d     = valid_q;
    last_d      = last_q;
    col_d       = col_q;
    rd_free     = 1'b0;
    load        = 1'b0;
    ld_bank     = rb_q;
    ld_col      = '0;
    case (state_q)
      IDLE: begin
        if (full_q[rb_q]) begin
          state_d = SEND;
          load    = 1'b1;
          ra_d    = '0;
          valid_d = 1'b1;
        end
      end
      SEND: begin
        if (valid_q && bus.alpha_u_col_tready) begin
          if (ra_q != ALast) begin
            ra_d   = ra_q + AW'(1);
            load   = 1'b1;
            ld_col = ra_q + AW'(1);
          end else begin
            rd_free     = 1'b1;
            rb_d        = ~rb_q;
            ra_d        = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            // Chaining straight into the other bank keeps back-to-back frames bubble-free.
            if (full_q[~rb_q]) begin
              load    = 1'b1;
              ld_bank = ~rb_q;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      last_d = (ld_col == ALast);
      for (int j = 0; j < J; j++) col_d[j*DW +: DW] = bank_q[ld_bank][j][ld_col];
    end
  end

  // The write side only completes a non-full bank and the read side only frees a full one,
  // so the two updates never target the same flag.
  always_comb begin
    full_d = full_q;
    if (rd_free) full_d[rb_q] = 1'b0;
    if (wr_last) full_d[wb_q] = 1'b1;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= '0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wj_q        <= '0;
      ra_q        <= '0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
      state_q     <= IDLE;
      col_q       <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      full_q      <= full_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      wj_q        <= wj_d;
      ra_q        <= ra_d;
      overflow_q  <= overflow_d;
      frame_cnt_q <= frame_cnt_d;
      state_q     <= state_d;
      col_q       <= col_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  // NOTE: bank storage is not reset; the full flags gate every read, so stale data is never emitted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int a = 0; a < A; a++) bank_q[wb_q][wj_q][a] <= norm[a*DW +: DW];
    end
  end

  assign bus.alpha_u_col        = col_q;
  assign bus.alpha_u_col_tvalid = valid_q;
  assign bus.alpha_u_col_tlast  = last_q;
  assign overflow               = overflow_q;
  assign frame_cnt              = frame_cnt_q;

endmodule

// File: tb/tb_beta2alpha_fix.sv
// Self-checking bench for beta2alpha_fix: frame-level reference model with a queue of expected beats.
module tb_beta2alpha_fix;

  localparam int J  = 4;
  localparam int A  = 4;
  localparam int DW = 8;

  typedef struct {
    logic [J*DW-1:0] data;
    bit              last;
  } beat_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        overflow;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  beta2alpha_fix_if #(.J(J), .A(A), .DW(DW)) bus ();

  beta2alpha_fix #(.J(J), .A(A), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frames buffered (0..2), partial frame, emitted-frame count, sticky overflow.
  beat_t exp_q[$];
  int    held, wcnt, done_m;
  bit    ovf_m;
  int    frm [J][A];
  int    cur_vec [A];
  bit    cur_valid;

  bit              smp_valid;
  logic [J*DW-1:0] smp_col;
  bit              smp_last;

  function automatic int sat_norm(int b, int m);
    int d;
    d = b - m;
    return (d < -128) ? -128 : d;
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic model_accept();
    int    m;
    beat_t bt;
    if (held == 2) begin
      ovf_m = 1'b1;
      return;
    end
    m = cur_vec[0];
    for (int a = 1; a < A; a++) if (cur_vec[a] > m) m = cur_vec[a];
    for (int a = 0; a < A; a++) frm[wcnt][a] = sat_norm(cur_vec[a], m);
    wcnt++;
    if (wcnt == J) begin
      for (int a = 0; a < A; a++) begin
        for (int j = 0; j < J; j++) bt.data[j*DW +: DW] = 8'(frm[j][a]);
        bt.last = (a == A-1);
        exp_q.push_back(bt);
      end
      held++;
      wcnt = 0;
    end
  endtask

  // One clock: sample at negedge, compare, advance model, then return at posedge+1.
  task automatic step();
    bit hs;
    int qsz;
    @(negedge clk);
    smp_valid = (bus.alpha_u_col_tvalid === 1'b1);
    smp_col   = bus.alpha_u_col;
    smp_last  = bus.alpha_u_col_tlast;
    if (smp_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got col=%h last=%b, expected no valid beat", smp_col, smp_last);
      end else if (smp_col !== exp_q[0].data || bus.alpha_u_col_tlast !== exp_q[0].last) begin
        n_fail++;
        $display("FAIL beat: got col=%h last=%b, expected col=%h last=%b",
                 smp_col, smp_last, exp_q[0].data, exp_q[0].last);
      end
    end
    n_checks++;
    if (overflow !== ovf_m) begin
      n_fail++;
      $display("FAIL overflow: got %b, expected %b", overflow, ovf_m);
    end
    n_checks++;
    if (frame_cnt !== 16'(done_m)) begin
      n_fail++;
      $display("FAIL frame_cnt: got %0d, expected %0d", frame_cnt, done_m);
    end
    hs  = smp_valid && (bus.alpha_u_col_tready === 1'b1);
    qsz = exp_q.size();
    if (cur_valid) model_accept();
    if (hs && qsz > 0) begin
      if (exp_q[0].last) begin
        held--;
        done_m++;
      end
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    cur_valid       = 1'b0;
    bus.beta_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drive_cur();
    for (int a = 0; a < A; a++) bus.beta[a*DW +: DW] = 8'(cur_vec[a]);
    cur_valid       = 1'b1;
    bus.beta_tvalid = 1'b1;
    step();
  endtask

  task automatic drive_vec(input int v0, input int v1, input int v2, input int v3);
    cur_vec = '{v0, v1, v2, v3};
    drive_cur();
  endtask

  task automatic drive_rand();
    for (int a = 0; a < A; a++) cur_vec[a] = rnd8();
    drive_cur();
  endtask

  task automatic drain(input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < budget) begin
      step();
      cycles++;
    end
    n_checks++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d beats still pending after %0d cycles, expected 0", exp_q.size(), cycles);
    end
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.beta_tvalid = 1'b0;
    bus.beta        = '0;
    cur_valid       = 1'b0;
    exp_q.delete();
    held   = 0;
    wcnt   = 0;
    done_m = 0;
    ovf_m  = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.alpha_u_col, bus.alpha_u_col_tvalid, bus.alpha_u_col_tlast, overflow, frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got col=%h valid=%b last=%b ovf=%b cnt=%0d, expected all 0",
               bus.alpha_u_col, bus.alpha_u_col_tvalid, bus.alpha_u_col_tlast, overflow, frame_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.alpha_u_col_tready = 1'b1;
    do_reset();
    idle(3);
  endtask

  task automatic test_single_frame();
    int cyc;
    bus.alpha_u_col_tready = 1'b1;
    drive_vec(10, 20, 30, 40);
    drive_vec(-5, 0, 5, -128);
    drive_vec(0, 0, 0, 0);
    drive_vec(127, -128, 0, 1);
    step();
    n_checks++;
    if (smp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_t1: got valid=%b, expected 0", smp_valid);
    end
    step();
    n_checks++;
    if (smp_valid !== 1'b1 || smp_col !== 32'h0000_F6E2 || smp_last !== 1'b0) begin
      n_fail++;
      $display("FAIL first_beat: got valid=%b col=%h last=%b, expected valid=1 col=0000f6e2 last=0",
               smp_valid, smp_col, smp_last);
    end
    idle(2);
    step();
    n_checks++;
    if (smp_col !== 32'h8200_8000 || smp_last !== 1'b1) begin
      n_fail++;
      $display("FAIL last_beat: got col=%h last=%b, expected col=82008000 last=1", smp_col, smp_last);
    end
    drain(20, cyc);
    idle(2);
    n_checks++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL single_frame_cnt: got %0d, expected 1", frame_cnt);
    end
  endtask

  task automatic test_saturation();
    int sat_exp [A] = '{0, -128, -128, -127};
    int cyc;
    bus.alpha_u_col_tready = 1'b1;
    drive_vec(127, -128, -1, 0);
    repeat (J-1) drive_rand();
    step();
    for (int a = 0; a < A; a++) begin
      step();
      n_checks++;
      if (smp_valid !== 1'b1 || smp_col[DW-1:0] !== 8'(sat_exp[a])) begin
        n_fail++;
        $display("FAIL saturation_lane%0d: got valid=%b n=%h, expected n=%h",
                 a, smp_valid, smp_col[DW-1:0], 8'(sat_exp[a]));
      end
    end
    drain(20, cyc);
    idle(2);
  endtask

  task automatic test_backpressure();
    logic [J*DW-1:0] hold;
    int cyc;
    bus.alpha_u_col_tready = 1'b1;
    repeat (J) drive_rand();
    idle(3);
    bus.alpha_u_col_tready = 1'b0;
    hold = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) hold = smp_col;
      else begin
        n_checks++;
        if (smp_valid !== 1'b1 || smp_col !== hold) begin
          n_fail++;
          $display("FAIL backpressure_hold: got valid=%b col=%h, expected valid=1 col=%h", smp_valid, smp_col, hold);
        end
      end
    end
    bus.alpha_u_col_tready = 1'b1;
    drain(20, cyc);
    idle(2);
  endtask

  task automatic test_random();
    int cyc;
    for (int k = 0; k < 200; k++) begin
      bus.alpha_u_col_tready = $urandom_range(1);
      if ($urandom_range(1) == 1) drive_rand();
      else step();
    end
    bus.alpha_u_col_tready = 1'b1;
    drain(50, cyc);
    idle(2);
  endtask

  task automatic test_overflow();
    int cyc;
    int base;
    do_reset();
    bus.alpha_u_col_tready = 1'b0;
    repeat (3*J) drive_rand();
    idle(2);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got %b, expected 1", overflow);
    end
    base = done_m;
    bus.alpha_u_col_tready = 1'b1;
    drain(50, cyc);
    n_checks++;
    if (cyc != 2*A) begin
      n_fail++;
      $display("FAIL overflow_drain_cycles: got %0d, expected %0d", cyc, 2*A);
    end
    idle(2);
    n_checks++;
    if (frame_cnt !== 16'd2 || done_m - base != 2) begin
      n_fail++;
      $display("FAIL overflow_frames: got %0d, expected 2", frame_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    bus.alpha_u_col_tready = 1'b1;
    drive_rand();
    drive_rand();
    do_reset();
    idle(3);
    repeat (J) drive_rand();
    drain(20, cyc);
    idle(2);
    n_checks++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_mid_frame_cnt: got %0d, expected 1", frame_cnt);
    end
  endtask

  task automatic test_bank_recycle();
    int cyc;
    do_reset();
    bus.alpha_u_col_tready = 1'b1;
    repeat (J) drive_rand();
    idle(1);
    repeat (J) drive_rand();
    idle(1);
    repeat (J) drive_rand();
    drain(40, cyc);
    idle(2);
    n_checks++;
    if (overflow !== 1'b0 || frame_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL bank_recycle: got ovf=%b cnt=%0d, expected ovf=0 cnt=3", overflow, frame_cnt);
    end
  endtask

  initial begin
    bus.beta               = '0;
    bus.beta_tvalid        = 1'b0;
    bus.alpha_u_col_tready = 1'b1;
    cur_valid              = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_frame();
    test_saturation();
    test_backpressure();
    test_random();
    test_overflow();
    test_reset_mid_frame();
    test_bank_recycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
